int2flt_seq: RTL

INT2FLT_SEQ -- requirements
Module: int2flt_seq

---
 rtl/int2flt_seq.sv | 116 +++++++++++
 1 files changed

// File: rtl/int2flt_seq.sv
// Sequential signed-integer to float converter: normalise by shifting, then round.
// Macro INT2FLT_ROUND_NEAREST_EVEN_EN selects round-to-nearest-even; otherwise truncate.
module int2flt_seq #(
    parameter int IN_W      = 16,
    parameter int EXP_W     = 5,
    parameter int MAN_W     = 10,
    parameter int TWOS_COMP = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [IN_W-1:0]        int_in,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   flt_out
);

    localparam int BIAS = 2**(EXP_W-1) - 1;
    // Weight of the mag register MSB: sign-magnitude drops the sign bit.
    localparam int TOP  = (TWOS_COMP != 0) ? IN_W-1 : IN_W-2;
    localparam int XW   = EXP_W + $clog2(IN_W) + 2;
    localparam logic [XW-1:0] EXP_INIT = XW'(BIAS + TOP);
    localparam logic [XW-1:0] EXP_MAX  = XW'(2**EXP_W - 1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [IN_W-1:0]        r_mag;
    logic [XW-1:0]          r_exp;
    logic                   r_sign;
    logic [EXP_W+MAN_W:0]   r_flt;

    logic [IN_W-1:0]        w_in_mag;
    logic                   w_mag_zero;
    logic [MAN_W-1:0]       w_man;
    logic                   w_rup;
    logic [MAN_W:0]         w_sum;
    logic [XW-1:0]          w_exp_r;
    logic [EXP_W+MAN_W:0]   w_flt;

    assign w_mag_zero = (r_mag == '0);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign flt_out    = r_flt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (start) w_next = NORM;
            NORM:  if (r_mag[IN_W-1] || w_mag_zero) w_next = ROUND;
            ROUND: w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        if (TWOS_COMP != 0)
            w_in_mag = int_in[IN_W-1] ? (~int_in + IN_W'(1)) : int_in;
        else
            w_in_mag = {int_in[IN_W-2:0], 1'b0};
    end

`ifdef INT2FLT_ROUND_NEAREST_EVEN_EN
    localparam int LW = IN_W + MAN_W;
    logic [LW-1:0] w_low;
    logic          w_guard;
    logic          w_sticky;
    // Bits below the MSB, zero-filled so short fields still yield MAN_W+1 bits.
    assign w_low    = {r_mag[IN_W-2:0], {(MAN_W+1){1'b0}}};
    assign w_man    = w_low[LW-1 -: MAN_W];
    assign w_guard  = w_low[LW-1-MAN_W];
    assign w_sticky = |w_low[LW-2-MAN_W:0];
    assign w_rup    = w_guard & (w_man[0] | w_sticky);
`else
    assign w_man = MAN_W'({r_mag[IN_W-2:0], {MAN_W{1'b0}}} >> (IN_W-1));
    assign w_rup = 1'b0;
`endif

    assign w_sum   = {1'b0, w_man} + (MAN_W+1)'(w_rup);
    assign w_exp_r = r_exp + XW'(w_sum[MAN_W]);

    always_comb begin
        w_flt = {r_sign, w_exp_r[EXP_W-1:0], w_sum[MAN_W-1:0]};
        if (w_mag_zero)
            w_flt = {r_sign, {(EXP_W+MAN_W){1'b0}}};
        else if (w_exp_r >= EXP_MAX)
            w_flt = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mag  <= '0;
            r_exp  <= '0;
            r_sign <= 1'b0;
            r_flt  <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_mag  <= w_in_mag;
                r_exp  <= EXP_INIT;
                r_sign <= int_in[IN_W-1];
            end else if (r_state == NORM && !r_mag[IN_W-1] && !w_mag_zero) begin
                r_mag <= {r_mag[IN_W-2:0], 1'b0};
                r_exp <= r_exp - XW'(1);
            end
            if (r_state == ROUND) r_flt <= w_flt;
        end
    end

endmodule
